mul_issue_ctrl: RTL and testbench

- Execute-stage front end for the radix-4 Booth multiplier.
- Accepts one RV64M multiply op from EX, sets operand signedness/width, drives the multiplier request handshake, and captures its one-cycle result pulse.
- Selects and sign-extends the architectural result and holds it until the downstream stage accepts it.
- Handles pipeline flush, including draining an in-flight multiplication.

---
 rtl/mul_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Execute-stage front end for the radix-4 Booth multiplier: latches one RV64M
// multiply op, issues it, captures the result pulse and holds the rd value until accepted.
module mul_issue_ctrl #(
  parameter int unsigned XLEN        = 64,
  parameter bit          ZERO_BYPASS = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            mul_req_valid,
  input  logic            mul_req_ready,
  output logic            mul_flush,
  output logic            mul_mulw,
  output logic [1:0]      mul_signed,
  output logic [XLEN-1:0] mul_multiplicand,
  output logic [XLEN-1:0] mul_multiplier,
  input  logic            mul_resp_valid,
  input  logic [XLEN-1:0] mul_result_hi,
  input  logic [XLEN-1:0] mul_result_lo
);

  localparam int unsigned HW = 32;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, data_q, data_d;
  logic [1:0]      sign_q, sign_d;
  logic            mulw_q, mulw_d, mflush_q, mflush_d;

  logic [2:0]      in_op_n;
  logic            in_mulw, in_zero;
  logic [1:0]      in_sign;
  logic [XLEN-1:0] eff1, eff2, res_sel;

  // Incoming op decode: reserved encodings run as MUL, MULW narrows both sources.
  always_comb begin
    in_op_n = (in_op > OP_MULW) ? OP_MUL : in_op;
    in_mulw = (in_op_n == OP_MULW);
    eff1    = in_mulw ? {{(XLEN-HW){in_src1[HW-1]}}, in_src1[HW-1:0]} : in_src1;
    eff2    = in_mulw ? {{(XLEN-HW){in_src2[HW-1]}}, in_src2[HW-1:0]} : in_src2;
    in_zero = ZERO_BYPASS && ((eff1 == '0) || (eff2 == '0));
    case (in_op_n)
      OP_MULHSU: in_sign = 2'b10;
      OP_MULHU:  in_sign = 2'b00;
      default:   in_sign = 2'b11;
    endcase
  end

  // Architectural result selection from the product halves.
  always_comb begin
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: res_sel = mul_result_hi;
      OP_MULW: res_sel = {{(XLEN-HW){mul_result_lo[HW-1]}}, mul_result_lo[HW-1:0]};
      default: res_sel = mul_result_lo;
    endcase
  end

  // Next state and next register values; flush takes priority in every state.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    mulw_d   = mulw_q;
    data_d   = data_q;
    mflush_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && in_valid) begin
          op_d     = in_op_n;
          mcand_d  = eff1;
          mplier_d = eff2;
          sign_d   = in_sign;
          mulw_d   = in_mulw;
          if (in_zero) begin
            data_d  = '0;
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mul_req_ready) begin
          state_d  = flush ? DRAIN : WAIT;
          mflush_d = flush;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d  = DRAIN;
          mflush_d = 1'b1;
        end else if (mul_resp_valid) begin
          data_d  = res_sel;
          state_d = DONE;
        end
      end
      DONE:    if (flush || out_ready) state_d = IDLE;
      DRAIN:   if (mul_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= '0;
      mulw_q   <= 1'b0;
      data_q   <= '0;
      mflush_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      mulw_q   <= mulw_d;
      data_q   <= data_d;
      mflush_q <= mflush_d;
    end
  end

  assign in_ready         = (state_q == IDLE);
  assign mul_req_valid    = (state_q == ISSUE);
  assign out_valid        = (state_q == DONE);
  assign out_data         = data_q;
  assign mul_flush        = mflush_q;
  assign mul_mulw         = mulw_q;
  assign mul_signed       = sign_q;
  assign mul_multiplicand = mcand_q;
  assign mul_multiplier   = mplier_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural multiplier and a result scoreboard.
module tb_mul_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [63:0] in_src1, in_src2, out_data;
  logic        mul_req_valid, mul_req_ready, mul_flush, mul_mulw, mul_resp_valid;
  logic [1:0]  mul_signed;
  logic [63:0] mul_multiplicand, mul_multiplier, mul_result_hi, mul_result_lo;

  int unsigned lat    = 3;
  bit          rdy_en = 1'b1;
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  mul_issue_ctrl #(.XLEN(64), .ZERO_BYPASS(1'b1)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mul_req_valid(mul_req_valid), .mul_req_ready(mul_req_ready),
    .mul_flush(mul_flush), .mul_mulw(mul_mulw), .mul_signed(mul_signed),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_resp_valid(mul_resp_valid), .mul_result_hi(mul_result_hi),
    .mul_result_lo(mul_result_lo)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] ext(input logic [63:0] v, input logic s);
    return {{64{s & v[63]}}, v};
  endfunction

  // Architectural RV64M result, computed from the raw sources.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  w;
    case (op)
      3'd1: begin p = ext(a, 1'b1) * ext(b, 1'b1); return p[127:64]; end
      3'd2: begin p = ext(a, 1'b1) * ext(b, 1'b0); return p[127:64]; end
      3'd3: begin p = ext(a, 1'b0) * ext(b, 1'b0); return p[127:64]; end
      3'd4: begin
        w = {32'b0, a[31:0]} * {32'b0, b[31:0]};
        return {{32{w[31]}}, w[31:0]};
      end
      default: return a * b;
    endcase
  endfunction

  // Multiplier model: handshake decided at the negedge before the sampling posedge.
  initial begin : mul_model
    bit           busy;
    int unsigned  cnt;
    logic [127:0] prod;
    busy = 1'b0; cnt = 0; prod = '0;
    mul_req_ready = 1'b0; mul_resp_valid = 1'b0;
    mul_result_hi = '0; mul_result_lo = '0;
    forever begin
      @(negedge clock);
      mul_resp_valid = 1'b0;
      if (reset) begin
        busy = 1'b0;
        mul_req_ready = 1'b0;
      end else if (busy) begin
        mul_req_ready = 1'b0;
        if (cnt == 0) begin
          mul_resp_valid = 1'b1;
          {mul_result_hi, mul_result_lo} = prod;
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end else begin
        mul_req_ready = rdy_en;
        if (mul_req_valid && mul_req_ready) begin
          prod = ext(mul_multiplicand, mul_signed[1]) * ext(mul_multiplier, mul_signed[0]);
          cnt  = lat - 1;
          busy = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 100) begin tick(); k++; end
    if (!out_valid) check({tag, "_timeout"}, 64'(out_valid), 64'd1);
    else check(tag, out_data, exp_q.pop_front());
    tick();
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp);
    exp_q.push_back(exp);
    issue(op, a, b);
    wait_out(tag);
  endtask

  initial begin : main
    bit       bad_a, bad_b;
    int       k;
    logic [2:0]  rop;
    logic [63:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_valid", 64'(mul_req_valid), 64'd0);
    check("rst_outs", {out_data | mul_multiplicand | mul_multiplier}, 64'd0);
    check("rst_ctl", 64'({mul_flush, mul_mulw, mul_signed}), 64'd0);

    // MUL with the multiplier stalling the request for a few cycles.
    rdy_en = 1'b0;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    issue(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
    check("mul_signed_mul", 64'(mul_signed), 64'd3);
    check("mul_in_ready_busy", 64'(in_ready), 64'd0);
    bad_a = 1'b0;
    repeat (3) begin
      bad_a |= !mul_req_valid || (mul_multiplier != 64'hFFFF_FFFF_FFFF_FFFB);
      tick();
    end
    check("mul_req_held", 64'(bad_a), 64'd0);
    rdy_en = 1'b1;
    check("mul_req_before_hs", 64'(mul_req_valid), 64'd1);
    tick();
    check("mul_req_after_hs", 64'(mul_req_valid), 64'd0);
    wait_out("mul_3x-5");
    check("mul_out_valid_drop", 64'(out_valid), 64'd0);

    run_op("mulhu_ones", 3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulh_ones", 3'd1, '1, '1, 64'h0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    issue(3'd2, '1, 64'd2);
    check("mulhsu_signed", 64'(mul_signed), 64'd2);
    wait_out("mulhsu_-1x2");

    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    issue(3'd4, 64'h1234_5678_7FFF_FFFF, 64'd2);
    check("mulw_mcand", mul_multiplicand, 64'h0000_0000_7FFF_FFFF);
    check("mulw_flag", 64'(mul_mulw), 64'd1);
    wait_out("mulw_result");
    run_op("op101_as_mul", 3'd5, 64'd11, 64'd13, 64'd143);

    // Zero bypass with a stalled consumer.
    out_ready = 1'b0;
    exp_q.push_back(64'd0);
    issue(3'd0, 64'd0, 64'd5);
    check("byp_out_valid", 64'(out_valid), 64'd1);
    check("byp_out_data", out_data, exp_q[0]);
    bad_a = 1'b0;
    repeat (10) begin
      bad_a |= !out_valid || (out_data != 64'd0) || in_ready || mul_req_valid;
      tick();
    end
    check("byp_hold", 64'(bad_a), 64'd0);
    out_ready = 1'b1;
    wait_out("byp_result");
    check("byp_in_ready_after", 64'(in_ready), 64'd1);

    // Flush while the multiplication is in flight.
    lat = 12;
    issue(3'd0, 64'd9, 64'd9);
    tick();
    check("flush_wait_no_req", 64'(mul_req_valid), 64'd0);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    check("flush_pulse", 64'(mul_flush), 64'd1);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("flush_single_pulse", 64'(mul_flush), 64'd0);
    bad_a = 1'b0; bad_b = 1'b0; k = 0;
    while (!in_ready && k < 50) begin
      bad_a |= out_valid; bad_b |= mul_flush;
      tick(); k++;
    end
    check("drain_exit", 64'(in_ready), 64'd1);
    check("drain_exit_on_resp", 64'(mul_resp_valid), 64'd1);
    check("drain_no_out", 64'(bad_a), 64'd0);
    check("drain_no_reflush", 64'(bad_b), 64'd0);
    lat = 3;
    run_op("after_drain_7x6", 3'd0, 64'd7, 64'd6, 64'd42);

    // Flush together with in_valid in IDLE drops the op.
    flush = 1'b1;
    issue(3'd0, 64'd4, 64'd4);
    flush = 1'b0;
    check("idle_flush_in_ready", 64'(in_ready), 64'd1);
    check("idle_flush_no_op", 64'(out_valid | mul_req_valid), 64'd0);

    // Flush in DONE; MULW with zero low word takes the bypass.
    out_ready = 1'b0;
    issue(3'd4, 64'h0000_0001_0000_0000, 64'd5);
    check("done_bypass_w", 64'(out_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    check("done_flush_out_valid", 64'(out_valid), 64'd0);
    check("done_flush_in_ready", 64'(in_ready), 64'd1);

    // Reset while waiting on the multiplier.
    lat = 10;
    issue(3'd3, '1, '1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_wait_state", 64'({in_ready, out_valid, mul_req_valid, mul_flush}), 64'b1000);
    check("rst_wait_regs", out_data | mul_multiplicand | mul_multiplier, 64'd0);
    check("rst_wait_ctl", 64'({mul_mulw, mul_signed}), 64'd0);
    lat = 3;

    repeat (4) begin
      rop = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      run_op("random_op", rop, ra, rb, ref_result(rop, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
